// File: rtl/uart_xmit_arbiter.sv
// Two-requester byte arbiter in front of a UART transmitter: burst-limited
// fairness, one-cycle launch strobe, start timeout and an inter-byte gap.
module uart_xmit_arbiter #(
  parameter int BURST_MAX  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int START_TMO  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_l,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        xmitH,
  output logic [7:0]  xmit_dataH,
  input  logic        xmit_doneH,
  output logic        grant_id,
  output logic        busy,
  output logic        tmo_err,
  output logic [15:0] tx_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
  // The launch cycle itself counts toward the START_TMO window.
  localparam logic [3:0] TMO_LAST  = 4'(START_TMO - 2);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] burst, burst_nx;
  logic [3:0] tmo_cnt, tmo_cnt_nx;
  logic [3:0] gap_cnt, gap_cnt_nx;
  logic       accept, winner, last_valid, tmo_hit, done_inc;

  always_comb begin
    last_valid = grant_id ? req1_valid : req0_valid;
    if (req0_valid && req1_valid)
      winner = (burst < BURST_LIM) ? grant_id : ~grant_id;
    else
      winner = req1_valid;
    // Gated by reset so the readies stay low while the block is held in reset.
    accept = sys_rst_l && (state == IDLE) && xmit_doneH && (req0_valid || req1_valid);
  end

  assign req0_ready = accept & ~winner;
  assign req1_ready = accept & winner;
  assign xmitH      = (state == LAUNCH);
  assign busy       = (state != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    burst_nx   = burst;
    tmo_cnt_nx = tmo_cnt;
    gap_cnt_nx = gap_cnt;
    tmo_hit    = 1'b0;
    done_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = LAUNCH;
          if (winner != grant_id)  burst_nx = 4'd1;
          else if (burst != 4'hF)  burst_nx = burst + 4'd1;
        end else if (!last_valid) begin
          burst_nx = 4'd0;
        end
      end
      LAUNCH: begin
        state_nx   = WAIT_LOW;
        tmo_cnt_nx = 4'd0;
      end
      WAIT_LOW: begin
        if (!xmit_doneH) begin
          state_nx = WAIT_HIGH;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_cnt_nx = tmo_cnt + 4'd1;
        end
      end
      WAIT_HIGH: begin
        if (xmit_doneH) begin
          done_inc   = 1'b1;
          gap_cnt_nx = 4'd0;
          state_nx   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nx = 4'd0;
          state_nx   = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      burst      <= 4'd0;
      tmo_cnt    <= 4'd0;
      gap_cnt    <= 4'd0;
      xmit_dataH <= 8'd0;
      grant_id   <= 1'b0;
      tmo_err    <= 1'b0;
      tx_count   <= 16'd0;
    end else begin
      burst   <= burst_nx;
      tmo_cnt <= tmo_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      if (accept) begin
        xmit_dataH <= winner ? req1_data : req0_data;
        grant_id   <= winner;
      end
      if (tmo_hit)  tmo_err  <= 1'b1;
      if (done_inc) tx_count <= tx_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// Bench for uart_xmit_arbiter: directed scenarios plus a randomized run
// against a cycle-level arbitration/transmitter reference model.
module tb_uart_xmit_arbiter;
  localparam int BURST_MAX  = 4;
  localparam int GAP_CYCLES = 2;
  localparam int START_TMO  = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_l = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = 8'd0, req1_data = 8'd0;
  logic        req0_ready, req1_ready, xmitH, grant_id, busy, tmo_err;
  logic [7:0]  xmit_dataH;
  logic        xmit_doneH = 1'b1;
  logic [15:0] tx_count;

  uart_xmit_arbiter #(.BURST_MAX(BURST_MAX), .GAP_CYCLES(GAP_CYCLES), .START_TMO(START_TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .xmitH(xmitH), .xmit_dataH(xmit_dataH), .xmit_doneH(xmit_doneH),
    .grant_id(grant_id), .busy(busy), .tmo_err(tmo_err), .tx_count(tx_count)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_xmitH"}, xmitH, 0);
    chk({tag, "_xmit_dataH"}, xmit_dataH, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tmo_err"}, tmo_err, 0);
    chk({tag, "_tx_count"}, tx_count, 0);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    sys_rst_l = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0; xmit_doneH = 1;
    @(negedge sys_clk);
    chk_zero("reset");
    @(posedge sys_clk); #3;
    sys_rst_l = 1'b1;
  endtask

  // One byte through the transmitter: done low for one cycle, then high, then settle.
  task automatic finish_xfer();
    @(posedge sys_clk); #1; xmit_doneH = 0;
    @(posedge sys_clk); #1; xmit_doneH = 1;
    repeat (GAP_CYCLES + 3) @(posedge sys_clk);
    #1;
  endtask

  // Reference model state for the randomized run.
  bit         last_g, xfer_active, p0, p1, exp_acc, win;
  int         bcnt, idle_from, launch_cyc, drop_at, rise_at, exp_tx;
  logic [7:0] d0, d1, acc_data;
  bit         grants[$];

  task automatic run_random(input int n, input bit contend);
    last_g = 0; bcnt = 0; idle_from = 0; launch_cyc = -1; xfer_active = 0; exp_tx = 0;
    p0 = 0; p1 = 0; grants.delete();
    for (int i = 0; i < n + 60; i++) begin
      @(posedge sys_clk); #1;
      if (i < n && !p0 && (contend || $urandom_range(0, 2) != 0)) begin p0 = 1; d0 = 8'($urandom); end
      if (i < n && !p1 && (contend || $urandom_range(0, 2) != 0)) begin p1 = 1; d1 = 8'($urandom); end
      req0_valid = p0; req0_data = d0; req1_valid = p1; req1_data = d1;
      if (xfer_active && cyc == rise_at + 1) begin exp_tx++; xfer_active = 0; end
      xmit_doneH = !(xfer_active && cyc >= drop_at && cyc < rise_at);
      @(negedge sys_clk);
      if (cyc >= idle_from && !(last_g ? p1 : p0)) bcnt = 0;
      exp_acc = (cyc >= idle_from) && (p0 || p1);
      win = 0;
      if (exp_acc) win = (p0 && p1) ? ((bcnt < BURST_MAX) ? last_g : !last_g) : p1;
      chk("ready", {req1_ready, req0_ready}, exp_acc ? (win ? 2'b10 : 2'b01) : 2'b00);
      chk("busy", busy, cyc < idle_from);
      chk("xmitH", xmitH, cyc == launch_cyc);
      chk("tx_count", tx_count, 32'(exp_tx));
      if (req0_ready || req1_ready) grants.push_back(req1_ready);
      if (cyc == launch_cyc) begin
        chk("xmit_dataH", xmit_dataH, acc_data);
        chk("grant_id", grant_id, last_g);
        drop_at = cyc + int'($urandom_range(1, START_TMO - 1));
        rise_at = drop_at + int'($urandom_range(1, 3));
        xfer_active = 1;
        idle_from = rise_at + GAP_CYCLES + 1;
      end
      if (exp_acc) begin
        acc_data = win ? d1 : d0;
        if (win) p1 = 0; else p0 = 0;
        bcnt = (win == last_g) ? ((bcnt < 15) ? bcnt + 1 : 15) : 1;
        last_g = win;
        launch_cyc = cyc + 1;
        idle_from = 32'h7fffffff;
      end
    end
    chk("final_tx_count", tx_count, 32'(exp_tx));
  endtask

  int  t_rise, t_rdy;
  bit  got;
  bit  exp_seq[9];

  initial begin
    // Single byte, then a queued byte from req1 to measure the gap.
    do_reset();
    @(posedge sys_clk); #1; req0_valid = 1; req0_data = 8'hA5;
    @(negedge sys_clk);
    chk("single_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge sys_clk); #1; req0_valid = 0; req1_valid = 1; req1_data = 8'h3C;
    @(negedge sys_clk);
    chk("single_xmitH", xmitH, 1);
    chk("single_data", xmit_dataH, 8'hA5);
    chk("single_grant", grant_id, 0);
    chk("ready_outside_idle", req1_ready, 0);
    @(posedge sys_clk); #1; xmit_doneH = 0;
    @(negedge sys_clk);
    chk("single_xmitH_once", xmitH, 0);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1; xmit_doneH = 1; t_rise = cyc;
    @(negedge sys_clk);
    chk("single_count_before", tx_count, 0);
    got = 0; t_rdy = -1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge sys_clk);
      if (req1_ready) begin got = 1; t_rdy = cyc; end
    end
    chk("gap_cycles", t_rdy - t_rise, 3);
    chk("single_count", tx_count, 1);
    @(posedge sys_clk); #1; req1_valid = 0;
    @(negedge sys_clk);
    chk("gap_grant", grant_id, 1);
    chk("gap_data", xmit_dataH, 8'h3C);
    finish_xfer();
    chk("two_bytes_count", tx_count, 2);

    // Randomized traffic against the model, then sustained contention.
    do_reset();
    run_random(1500, 0);
    do_reset();
    run_random(200, 1);
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    chk("contend_len_ok", grants.size() >= 9, 1);
    for (int k = 0; k < 9; k++) chk("contend_seq", grants[k], exp_seq[k]);

    // Stuck transmitter, then recovery and a withdrawn request.
    do_reset();
    @(posedge sys_clk); #1; req0_valid = 1; req0_data = 8'h11;
    @(negedge sys_clk);
    chk("tmo_ready", req0_ready, 1);
    @(posedge sys_clk); #1; req0_valid = 0;
    @(negedge sys_clk);
    chk("tmo_xmitH", xmitH, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk);
      chk("tmo_err_timing", tmo_err, i == 4);
      chk("tmo_busy", busy, i != 4);
    end
    chk("tmo_count", tx_count, 0);
    @(posedge sys_clk); #1; req1_valid = 1; req1_data = 8'h22;
    @(negedge sys_clk);
    chk("after_tmo_ready", req1_ready, 1);
    @(posedge sys_clk); #1; req1_valid = 0;
    @(negedge sys_clk);
    chk("after_tmo_data", xmit_dataH, 8'h22);
    @(posedge sys_clk); #1; xmit_doneH = 0; req0_valid = 1; req0_data = 8'h33;
    @(negedge sys_clk);
    chk("withdraw_ready_a", req0_ready, 0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    chk("withdraw_ready_b", req0_ready, 0);
    @(posedge sys_clk); #1; req0_valid = 0; xmit_doneH = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      chk("withdraw_quiet", {req1_ready, req0_ready, xmitH}, 3'b000);
    end
    chk("withdraw_count", tx_count, 1);
    chk("tmo_sticky", tmo_err, 1);

    // Asynchronous reset while waiting for done to return high.
    do_reset();
    @(posedge sys_clk); #1; req1_valid = 1; req1_data = 8'h5A;
    @(negedge sys_clk);
    chk("rst_pre_ready", req1_ready, 1);
    @(posedge sys_clk); #1; req1_data = 8'h77;
    @(negedge sys_clk);
    chk("rst_pre_grant", grant_id, 1);
    @(posedge sys_clk); #1; xmit_doneH = 0;
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    chk("rst_pre_busy", busy, 1);
    #2 sys_rst_l = 0;
    #1 chk_zero("async_rst");
    @(posedge sys_clk); #1; xmit_doneH = 1;
    @(negedge sys_clk);
    chk_zero("held_rst");
    @(posedge sys_clk); #3 sys_rst_l = 1;
    @(negedge sys_clk);
    chk("post_rst_ready", {req1_ready, req0_ready}, 2'b10);
    @(posedge sys_clk); #1; req1_valid = 0;
    @(negedge sys_clk);
    chk("post_rst_grant", grant_id, 1);
    chk("post_rst_data", xmit_dataH, 8'h77);
    finish_xfer();
    chk("post_rst_count", tx_count, 1);

    // Counter wrap from 0xFFFF.
    @(negedge sys_clk);
    force dut.tx_count = 16'hFFFF;
    #1 release dut.tx_count;
    #1 chk("wrap_preload", tx_count, 16'hFFFF);
    @(posedge sys_clk); #1; req0_valid = 1; req0_data = 8'hEE;
    @(posedge sys_clk); #1; req0_valid = 0;
    @(negedge sys_clk);
    chk("wrap_xmitH", xmitH, 1);
    finish_xfer();
    chk("wrap_count", tx_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_xmit_arbiter.md
UART_XMIT_ARBITER -- requirements
Module: uart_xmit_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4: maximum consecutive bytes granted to one requester while the other is requesting (range 1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles between xmit_doneH returning high and the next launch (range 0..15).
REQ-003 SHALL have parameter START_TMO, default 4: cycles allowed after launch for xmit_doneH to drop (range 2..15).
REQ-004 sys_clk  in  1  clock; all state changes on its rising edge.
REQ-005 sys_rst_l  in  1  reset, asynchronous, active-low.
REQ-006 req0_valid  in  1  requester 0 has a byte.
REQ-007 req0_data  in  8  requester 0 byte, stable while req0_valid is high.
REQ-008 req0_ready  out  1  one-cycle pulse: requester 0 byte accepted.
REQ-009 req1_valid, req1_data, req1_ready: same as REQ-006..008 for requester 1.
REQ-010 xmitH  out  1  one-cycle launch strobe to the transmitter.
REQ-011 xmit_dataH  out  8  byte to transmit, registered, held from launch until the next acceptance.
REQ-012 xmit_doneH  in  1  transmitter idle/done level (high = idle).
REQ-013 grant_id  out  1  requester owning the current or last byte.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 tmo_err  out  1  sticky start-timeout flag.
REQ-016 tx_count  out  16  count of completed bytes.

Function
REQ-017 States: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, GAP.
REQ-018 IDLE, with xmit_doneH high and at least one valid: select a winner, pulse its ready, capture its data into xmit_dataH, set grant_id, go to LAUNCH; no action while xmit_doneH is low.
REQ-019 Selection: only one valid -> that requester; both valid -> last grantee if its burst count is below BURST_MAX, else the other.
REQ-020 Burst count: 4 bits; reset to 1 when the winner differs from the last grantee; incremented (saturating at 15) when the winner is the same.
REQ-021 Burst count: forced to 0 when the last grantee's valid is low in IDLE.
REQ-022 LAUNCH: xmitH high for exactly this one cycle; then WAIT_LOW with the timeout counter at 0.
REQ-023 WAIT_LOW: xmit_doneH low -> WAIT_HIGH.
REQ-024 WAIT_LOW: otherwise the counter increments; reaching START_TMO sets tmo_err and goes to IDLE without incrementing tx_count.
REQ-025 WAIT_HIGH: xmit_doneH high -> increment tx_count (wrap 0xFFFF->0x0000), then GAP if GAP_CYCLES>0, else IDLE; no timeout in this state.
REQ-026 GAP: count GAP_CYCLES cycles, then IDLE.
REQ-027 Latency: ready pulse to xmitH is 1 cycle; at most one ready per byte; ready is never asserted outside IDLE.
REQ-028 Valid deasserting before acceptance: no ready, no byte sent, no error.
REQ-029 Once tmo_err is set it stays set until reset; arbitration continues normally.
REQ-030 Illegal state encoding: recover to IDLE on the next clock.

Reset
REQ-031 While sys_rst_l is low: state IDLE, all outputs 0 (xmitH, req0_ready, req1_ready, xmit_dataH, grant_id, busy, tmo_err, tx_count), burst and gap counters 0.
REQ-032 Reset asserted mid-transfer aborts immediately; after release, arbitration resumes in IDLE with grant_id=0 treated as last grantee.

Verification
REQ-033 Single byte: req0 sends 0xA5 with the transmitter model idle -> req0_ready 1 cycle, xmitH next cycle with xmit_dataH=0xA5, tx_count=1 after xmit_doneH returns high.
REQ-034 Contention: both valid continuously, BURST_MAX=4 -> grant sequence 0,0,0,0,1,1,1,1,0...; each byte launched exactly once.
REQ-035 Gap: GAP_CYCLES=2 -> exactly 3 cycles from xmit_doneH rising to the next ready pulse (2 GAP plus 1 IDLE).
REQ-036 Stuck transmitter: xmit_doneH held high after launch, START_TMO=4 -> tmo_err=1 four cycles after xmitH; tx_count unchanged; next byte still accepted.
REQ-037 Reset during WAIT_HIGH -> all outputs 0 asynchronously; after release, a pending req1 is granted and grant_id=1.
REQ-038 Wrap: preload tx_count near 0xFFFF via 65536 bytes or force -> 0xFFFF+1 reads 0x0000.
